spi_flash_responder: RTL and testbench

- Synthesizable SPI flash target that answers the flash-read traffic produced by the SoC's SPI memory controller. It is used for FPGA emulation when no physical flash part is fitted.
- It decodes serial commands on the flash pins and fetches bytes from a byte-wide synchronous memory port (BRAM image of firmware). It shifts those bytes back MSB-first.
- Single-clock design: SPI pins are oversampled; clk must be at least 4x flash_clk.

---
 rtl/spi_flash_responder_if.sv | 26 ++
 rtl/spi_flash_responder.sv | 170 +++++++++++++++++
 tb/tb_spi_flash_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// Pin and backing-memory bundle for spi_flash_responder.
// The master side drives the flash pins and memory read data; the slave side is the responder.
interface spi_flash_responder_if #(
  parameter int unsigned ADDR_BITS = 24
);
  logic                 flash_csb;
  logic                 flash_clk;
  logic                 flash_io0;
  logic                 flash_io1_out;
  logic                 flash_io1_oeb;
  logic                 mem_rd;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_rdata;
  logic                 busy;
  logic                 cmd_err;

  modport master (
    output flash_csb, flash_clk, flash_io0, mem_rdata,
    input  flash_io1_out, flash_io1_oeb, mem_rd, mem_addr, busy, cmd_err
  );

  modport slave (
    input  flash_csb, flash_clk, flash_io0, mem_rdata,
    output flash_io1_out, flash_io1_oeb, mem_rd, mem_addr, busy, cmd_err
  );
endinterface

// File: rtl/spi_flash_responder.sv
// Oversampled SPI flash read target backed by a byte-wide synchronous memory port.
// Define FAST_READ_EN to accept opcode 0x0B (fast read with 8 dummy clocks).
module spi_flash_responder #(
  parameter int unsigned ADDR_BITS   = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   reset,
  spi_flash_responder_if.slave  io_bus
);

  localparam int unsigned CntW = $clog2(ADDR_BITS) + 1;

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StData, StIgnore
  } state_e;

  state_e r_state, w_state_d;

  logic [SYNC_STAGES-1:0] r_csb_sync, r_sck_sync, r_io0_sync;
  logic                   r_sck_prev, r_armed, r_fast;
  logic [CntW-1:0]        r_cnt;
  logic [ADDR_BITS-1:0]   r_shift, r_mem_addr;
  logic [7:0]             r_tx, r_hold;
  logic [2:0]             r_tx_bit;
  logic                   r_tx_empty, r_mem_rd, r_rd_dly, r_io1;

  logic                 w_csb, w_sck, w_io0, w_sck_rise, w_sck_fall;
  logic                 w_last_byte_bit, w_last_addr_bit;
  logic [ADDR_BITS-1:0] w_shift_next;
  logic [7:0]           w_opcode, w_tx_cur, w_hold_cur;
  logic                 w_op_read, w_op_fast, w_op_quiet;
  logic                 w_busy, w_oeb, w_cmd_err;

  assign w_csb           = r_csb_sync[SYNC_STAGES-1];
  assign w_sck           = r_sck_sync[SYNC_STAGES-1];
  assign w_io0           = r_io0_sync[SYNC_STAGES-1];
  assign w_sck_rise      = w_sck & ~r_sck_prev;
  assign w_sck_fall      = ~w_sck & r_sck_prev;
  assign w_last_byte_bit = (r_cnt == CntW'(7));
  assign w_last_addr_bit = (r_cnt == CntW'(ADDR_BITS - 1));
  assign w_shift_next    = {r_shift[ADDR_BITS-2:0], w_io0};
  assign w_opcode        = w_shift_next[7:0];
  // Read data returning this cycle bypasses the registers so a fast flash_clk still sees it.
  assign w_tx_cur        = (r_tx_empty && r_rd_dly) ? io_bus.mem_rdata : r_tx;
  assign w_hold_cur      = (!r_tx_empty && r_rd_dly) ? io_bus.mem_rdata : r_hold;

  always_comb begin
    w_op_read  = (w_opcode == 8'h03);
    w_op_fast  = 1'b0;
`ifdef FAST_READ_EN
    w_op_fast  = (w_opcode == 8'h0B);
`else
    w_op_fast  = 1'b0;
`endif
    w_op_quiet = (w_opcode == 8'hAB) || (w_opcode == 8'hFF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (r_armed && !w_csb) w_state_d = StCmd;
      StCmd:    if (w_sck_rise && w_last_byte_bit) begin
                  w_state_d = (w_op_read || w_op_fast) ? StAddr : StIgnore;
                end
      StAddr:   if (w_sck_rise && w_last_addr_bit) w_state_d = r_fast ? StDummy : StData;
      StDummy:  if (w_sck_rise && w_last_byte_bit) w_state_d = StData;
      default:  w_state_d = r_state;
    endcase
    // Deselect wins over any edge seen in the same cycle.
    if (r_state != StIdle && w_csb) w_state_d = StIdle;
  end

  always_comb begin
    w_busy    = (r_state != StIdle);
    w_oeb     = (r_state != StData);
    w_cmd_err = (r_state == StCmd) && !w_csb && w_sck_rise && w_last_byte_bit &&
                !(w_op_read || w_op_fast || w_op_quiet);
  end

  // csb sync resets low so a transfer already in flight at reset release is ignored until deselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csb_sync <= '0;
      r_sck_sync <= '0;
      r_io0_sync <= '0;
      r_sck_prev <= 1'b0;
      r_armed    <= 1'b0;
      r_fast     <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_rd_dly   <= 1'b0;
      r_tx       <= '0;
      r_hold     <= '0;
      r_tx_bit   <= '0;
      r_tx_empty <= 1'b1;
      r_io1      <= 1'b0;
    end else begin
      r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], io_bus.flash_csb};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], io_bus.flash_clk};
      r_io0_sync <= {r_io0_sync[SYNC_STAGES-2:0], io_bus.flash_io0};
      r_sck_prev <= w_sck;
      r_rd_dly   <= r_mem_rd;
      r_mem_rd   <= 1'b0;
      if (w_csb) r_armed <= 1'b1;

      if (w_state_d == StIdle) begin
        r_cnt    <= '0;
        r_shift  <= '0;
        r_tx_bit <= '0;
      end else if (w_state_d != r_state) begin
        r_cnt <= '0;
      end else if (w_sck_rise &&
                   (r_state == StCmd || r_state == StAddr || r_state == StDummy)) begin
        r_cnt <= r_cnt + CntW'(1);
      end

      if (w_sck_rise && w_state_d != StIdle && (r_state == StCmd || r_state == StAddr)) begin
        r_shift <= w_shift_next;
      end

      if (r_state == StCmd && w_state_d == StAddr) r_fast <= w_op_fast;

      if (r_rd_dly) begin
        if (r_tx_empty) begin
          r_tx       <= io_bus.mem_rdata;
          r_tx_empty <= 1'b0;
        end else begin
          r_hold <= io_bus.mem_rdata;
        end
      end

      if (r_state == StAddr && (w_state_d == StData || w_state_d == StDummy)) begin
        r_mem_addr <= w_shift_next;
        r_mem_rd   <= 1'b1;
        r_tx_empty <= 1'b1;
        r_tx_bit   <= '0;
      end

      if (r_state == StData && w_state_d == StData && w_sck_fall) begin
        r_io1      <= w_tx_cur[7];
        r_tx_empty <= 1'b0;
        r_tx       <= (r_tx_bit == 3'd7) ? w_hold_cur : {w_tx_cur[6:0], 1'b0};
        r_tx_bit   <= r_tx_bit + 3'd1;
        if (r_tx_bit == 3'd0) begin
          r_mem_addr <= r_mem_addr + ADDR_BITS'(1);
          r_mem_rd   <= 1'b1;
        end
      end
    end
  end

  assign io_bus.flash_io1_out = r_io1;
  assign io_bus.flash_io1_oeb = w_oeb;
  assign io_bus.mem_rd        = r_mem_rd;
  assign io_bus.mem_addr      = r_mem_addr;
  assign io_bus.busy          = w_busy;
  assign io_bus.cmd_err       = w_cmd_err;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a mode-0 SPI controller at 12 clk per flash_clk
// plus a one-cycle-latency memory model.
module tb_spi_flash_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;

  logic [23:0] rd_q[$];
  int          err_cnt;
  logic        oeb_low_seen;

  spi_flash_responder_if #(.ADDR_BITS(24)) bus ();

  spi_flash_responder #(.ADDR_BITS(24), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000100: mem_byte = 8'hDE;
      24'h000101: mem_byte = 8'hAD;
      24'h000102: mem_byte = 8'hBE;
      24'h000103: mem_byte = 8'hEF;
      24'hFFFFFF: mem_byte = 8'h11;
      24'h000000: mem_byte = 8'h22;
      default:    mem_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem_byte(bus.mem_addr);
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.mem_rd) rd_q.push_back(bus.mem_addr);
      if (bus.cmd_err) err_cnt = err_cnt + 1;
      if (!bus.flash_io1_oeb) oeb_low_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete();
    err_cnt = 0;
    oeb_low_seen = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.flash_csb = 1'b0;
    #60;
  endtask

  task automatic end_frame();
    #60;
    bus.flash_csb = 1'b1;
    #120;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.flash_io0 = b[i];
      #60 bus.flash_clk = 1'b1;
      #60 bus.flash_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [23:0] addr);
    send_bits(op, 8);
    send_bits(addr[23:16], 8);
    send_bits(addr[15:8], 8);
    send_bits(addr[7:0], 8);
  endtask

  task automatic read_byte(output logic [7:0] v);
    bus.flash_io0 = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #57 v[i] = bus.flash_io1_out;
      #3  bus.flash_clk = 1'b1;
      #60 bus.flash_clk = 1'b0;
    end
  endtask

  int in_range;
  logic [7:0] b0, b1, b2, b3;

  initial begin
    bus.flash_csb = 1'b1;
    bus.flash_clk = 1'b0;
    bus.flash_io0 = 1'b0;
    bus.mem_rdata = 8'h00;
    clear_mon();
    #33;
    check("rst_io1_out", {31'd0, bus.flash_io1_out}, 32'd0);
    check("rst_io1_oeb", {31'd0, bus.flash_io1_oeb}, 32'd1);
    check("rst_mem_rd",  {31'd0, bus.mem_rd},        32'd0);
    check("rst_mem_addr", {8'd0, bus.mem_addr},      32'd0);
    check("rst_busy",    {31'd0, bus.busy},          32'd0);
    check("rst_cmd_err", {31'd0, bus.cmd_err},       32'd0);
    @(negedge clk);
    reset = 1'b0;
    #100;

    // Plain read of four bytes at 0x100
    clear_mon();
    start_frame();
    send_cmd(8'h03, 24'h000100);
    read_byte(b0); read_byte(b1); read_byte(b2); read_byte(b3);
    #60;
    check("read4_data", {b0, b1, b2, b3}, 32'hDEADBEEF);
    check("read4_busy", {31'd0, bus.busy}, 32'd1);
    in_range = 0;
    foreach (rd_q[i]) if (rd_q[i] >= 24'h100 && rd_q[i] <= 24'h103) in_range++;
    check("read4_rd_cnt", in_range, 4);
    check("read4_first_addr", {8'd0, rd_q[0]}, 32'h100);
    check("read4_no_err", err_cnt, 0);
    end_frame();
    check("read4_busy_off", {31'd0, bus.busy}, 32'd0);
    check("read4_oeb_off", {31'd0, bus.flash_io1_oeb}, 32'd1);

    // Controller init: 0xFF then 0xAB, each in its own frame
    clear_mon();
    start_frame(); send_bits(8'hFF, 8); end_frame();
    check("init_ff_busy", {31'd0, bus.busy}, 32'd0);
    start_frame(); send_bits(8'hAB, 8); end_frame();
    check("init_ab_busy", {31'd0, bus.busy}, 32'd0);
    check("init_no_err", err_cnt, 0);
    check("init_oeb_high", {31'd0, oeb_low_seen}, 32'd0);

    // Unsupported opcode, then a recovery read
    clear_mon();
    start_frame(); send_bits(8'h9F, 8); send_bits(8'h00, 8); end_frame();
    check("bad_op_err", err_cnt, 1);
    check("bad_op_oeb", {31'd0, oeb_low_seen}, 32'd0);
    check("bad_op_no_rd", rd_q.size(), 0);
    start_frame(); send_cmd(8'h03, 24'h000100); read_byte(b0); end_frame();
    check("bad_op_recover", {24'd0, b0}, 32'hDE);

    // Address wrap
    clear_mon();
    start_frame(); send_cmd(8'h03, 24'hFFFFFF); read_byte(b0); read_byte(b1); end_frame();
    check("wrap_data", {16'd0, b0, b1}, 32'h1122);
    check("wrap_addr0", {8'd0, rd_q[0]}, 32'hFFFFFF);
    check("wrap_addr1", {8'd0, rd_q[1]}, 32'h000000);

    // Abort after 12 address bits, then a normal read at 4
    clear_mon();
    start_frame(); send_bits(8'h03, 8); send_bits(8'h00, 8); send_bits(8'h00, 4); end_frame();
    check("abort_no_rd", rd_q.size(), 0);
    start_frame(); send_cmd(8'h03, 24'h000004); read_byte(b0); end_frame();
    check("abort_next_read", {24'd0, b0}, 32'h5E);

    // Fast read frame
    clear_mon();
    start_frame(); send_cmd(8'h0B, 24'h000100); send_bits(8'h00, 8); read_byte(b0); end_frame();
`ifdef FAST_READ_EN
    check("fast_data", {24'd0, b0}, 32'hDE);
    check("fast_no_err", err_cnt, 0);
`else
    check("fast_err", err_cnt, 1);
    check("fast_no_rd", rd_q.size(), 0);
    check("fast_oeb", {31'd0, oeb_low_seen}, 32'd0);
`endif

    // Reset in the middle of a frame: remainder must be ignored
    start_frame(); send_bits(8'h03, 8); send_bits(8'h00, 8);
    @(negedge clk); reset = 1'b1;
    #30 reset = 1'b0;
    clear_mon();
    send_bits(8'h01, 8); send_bits(8'h00, 8);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    read_byte(b0);
    end_frame();
    check("rst_mid_no_rd", rd_q.size(), 0);
    check("rst_mid_oeb", {31'd0, oeb_low_seen}, 32'd0);
    start_frame(); send_cmd(8'h03, 24'h000103); read_byte(b0); end_frame();
    check("rst_mid_recover", {24'd0, b0}, 32'hEF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
